trdb_packet_reader: RTL and testbench

Receive-side counterpart of the trace encoder's packet output path. Accepts the encoder's byte-serialised packet stream (one header byte, then payload bytes), reassembles each packet into a parallel word, and presents it on a valid/ready interface to the debug-host or decoder logic. It sits at the far end of the trace link, after the transport FIFO. It is used both in silicon-side loopback checking and as the front end of the software-model comparison bench.

---
 rtl/trdb_packet_reader.sv | 155 +++++++++++++++
 tb/tb_trdb_packet_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_reader.sv
// Reassembles a byte-serialised trace packet stream (header + payload) into a parallel word.
// Optional packet/drop counters are enabled with `TRDB_PACKET_READER_CNT_EN.
module trdb_packet_reader #(
    parameter int PAYLOAD_BYTES = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       byte_valid_i,
    input  logic [7:0]                 byte_i,
    output logic                       byte_ready_o,
    output logic                       pkt_valid_o,
    input  logic                       pkt_ready_i,
    output logic [4:0]                 pkt_len_o,
    output logic [1:0]                 pkt_flow_o,
    output logic [8*PAYLOAD_BYTES-1:0] pkt_payload_o,
    output logic                       err_oversize_o
`ifdef TRDB_PACKET_READER_CNT_EN
    ,
    output logic [31:0]                pkt_count_o,
    output logic [31:0]                drop_count_o
`endif
);

    localparam logic [4:0] MAX_LEN = 5'(PAYLOAD_BYTES);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP, OUTPUT} state_t;

    state_t                     state_q, state_d;
    logic [4:0]                 len_q, len_d;
    logic [1:0]                 flow_q, flow_d;
    logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
    logic [4:0]                 idx_q, idx_d;
    logic [4:0]                 drop_q, drop_d;
    logic                       err_q, err_d;
    logic                       byte_fire;
    logic [4:0]                 hdr_len;
    logic                       hdr_unused;

    // Header bit 7 carries no meaning for the reader.
    assign hdr_unused = byte_i[7];

    assign byte_ready_o   = !reset_i && (state_q != OUTPUT);
    assign byte_fire      = byte_valid_i && byte_ready_o;
    assign hdr_len        = byte_i[4:0];
    assign pkt_valid_o    = (state_q == OUTPUT);
    assign pkt_len_o      = len_q;
    assign pkt_flow_o     = flow_q;
    assign pkt_payload_o  = payload_q;
    assign err_oversize_o = err_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        flow_d    = flow_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        drop_d    = drop_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-length header is link filler and is simply swallowed.
                if (byte_fire && hdr_len != 5'd0) begin
                    if (hdr_len <= MAX_LEN) begin
                        len_d     = hdr_len;
                        flow_d    = byte_i[6:5];
                        payload_d = '0;
                        idx_d     = 5'd0;
                        state_d   = PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        drop_d  = hdr_len;
                        state_d = DROP;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_fire) begin
                    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
                        if (idx_q == 5'(k)) begin
                            payload_d[8*k +: 8] = byte_i;
                        end
                    end
                    idx_d = idx_q + 5'd1;
                    if (idx_q == len_q - 5'd1) begin
                        state_d = OUTPUT;
                    end
                end
            end
            DROP: begin
                if (byte_fire) begin
                    drop_d = drop_q - 5'd1;
                    if (drop_q == 5'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            OUTPUT: begin
                if (pkt_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            len_q     <= 5'd0;
            flow_q    <= 2'd0;
            payload_q <= '0;
            idx_q     <= 5'd0;
            drop_q    <= 5'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            flow_q    <= flow_d;
            payload_q <= payload_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

`ifdef TRDB_PACKET_READER_CNT_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pkt_valid_o && pkt_ready_i) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if (err_d) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pkt_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count_o  = pkt_cnt_q;
    assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_trdb_packet_reader.sv
// Self-checking bench for trdb_packet_reader: vector table plus hand-written corner sequences.
module tb_trdb_packet_reader;

    localparam int PB = 16;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            byte_valid_i;
    logic [7:0]      byte_i;
    logic            byte_ready_o;
    logic            pkt_valid_o;
    logic            pkt_ready_i;
    logic [4:0]      pkt_len_o;
    logic [1:0]      pkt_flow_o;
    logic [8*PB-1:0] pkt_payload_o;
    logic            err_oversize_o;
`ifdef TRDB_PACKET_READER_CNT_EN
    logic [31:0]     pkt_count_o;
    logic [31:0]     drop_count_o;
`endif

    trdb_packet_reader #(.PAYLOAD_BYTES(PB)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .byte_valid_i  (byte_valid_i),
        .byte_i        (byte_i),
        .byte_ready_o  (byte_ready_o),
        .pkt_valid_o   (pkt_valid_o),
        .pkt_ready_i   (pkt_ready_i),
        .pkt_len_o     (pkt_len_o),
        .pkt_flow_o    (pkt_flow_o),
        .pkt_payload_o (pkt_payload_o),
        .err_oversize_o(err_oversize_o)
`ifdef TRDB_PACKET_READER_CNT_EN
        ,
        .pkt_count_o   (pkt_count_o),
        .drop_count_o  (drop_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]      len;
        logic [1:0]      flow;
        logic [8*PB-1:0] pl;
    } pkt_t;

    typedef struct {
        logic [7:0]      hdr;
        int              nbytes;
        logic [255:0]    data;
        bit              exp_pkt;
        logic [4:0]      exp_len;
        logic [1:0]      exp_flow;
        logic [8*PB-1:0] exp_pl;
        int              exp_err;
    } tv_t;

    pkt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    int   cyc = 0;
    int   rise_cyc = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [8*PB-1:0] act, input logic [8*PB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard sink, sampled on the falling edge.
    always @(negedge clk_i) begin
        pkt_t e;
        if (err_oversize_o === 1'b1) err_seen++;
        if (pkt_valid_o === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = (pkt_valid_o === 1'b1);
        if (pkt_valid_o === 1'b1 && pkt_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: got len %0d flow %0d payload %h, expected none",
                         pkt_len_o, pkt_flow_o, pkt_payload_o);
            end else begin
                e = exp_q.pop_front();
                chk("pkt_len", 128'(pkt_len_o), 128'(e.len));
                chk("pkt_flow", 128'(pkt_flow_o), 128'(e.flow));
                chk("pkt_payload", pkt_payload_o, e.pl);
            end
        end
    end

    task automatic push_exp(input logic [4:0] len, input logic [1:0] flow, input logic [8*PB-1:0] pl);
        pkt_t p;
        p.len  = len;
        p.flow = flow;
        p.pl   = pl;
        exp_q.push_back(p);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid_i = 1'b1;
        byte_i       = b;
        @(negedge clk_i);
        while (!byte_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte_ready_o stuck at %b, required 1", byte_ready_o);
        end
        @(posedge clk_i);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        chk("drain_queue", 128'(exp_q.size()), 128'd0);
        idle(2);
    endtask

    tv_t tv[8];

    initial begin
        int e0;
        int c0;
        logic [8*PB-1:0] held;
`ifdef TRDB_PACKET_READER_CNT_EN
        logic [31:0] pc0, dc0;
`endif
        tv[0] = '{8'h43, 3,  256'hCCBBAA, 1, 5'd3, 2'd2, 128'hCCBBAA, 0};
        tv[1] = '{8'h10, 16, 256'h0F0E0D0C0B0A09080706050403020100, 1, 5'd16, 2'd0,
                  128'h0F0E0D0C0B0A09080706050403020100, 0};
        tv[2] = '{8'h22, 2,  256'h2211, 1, 5'd2, 2'd1, 128'h2211, 0};
        tv[3] = '{8'h00, 0,  256'h0, 0, 5'd0, 2'd0, 128'h0, 0};
        tv[4] = '{8'hA1, 1,  256'h3C, 1, 5'd1, 2'd1, 128'h3C, 0};
        tv[5] = '{8'h65, 5,  256'h5544332211, 1, 5'd5, 2'd3, 128'h5544332211, 0};
        tv[6] = '{8'h51, 17, {8{32'hDEADBEEF}}, 0, 5'd0, 2'd0, 128'h0, 1};
        tv[7] = '{8'h7F, 31, {8{32'h13579BDF}}, 0, 5'd0, 2'd0, 128'h0, 1};

        reset_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_i       = 8'h43;
        pkt_ready_i  = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_byte_ready", 128'(byte_ready_o), 128'd0);
        chk("rst_pkt_valid", 128'(pkt_valid_o), 128'd0);
        chk("rst_len_flow", 128'({pkt_len_o, pkt_flow_o}), 128'd0);
        chk("rst_payload", pkt_payload_o, 128'd0);
        chk("rst_err", 128'(err_oversize_o), 128'd0);
`ifdef TRDB_PACKET_READER_CNT_EN
        chk("rst_counters", 128'({pkt_count_o, drop_count_o}), 128'd0);
`endif
        @(posedge clk_i);
        #1;
        byte_valid_i = 1'b0;
        reset_i      = 1'b0;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            e0 = err_seen;
            if (tv[i].exp_pkt) push_exp(tv[i].exp_len, tv[i].exp_flow, tv[i].exp_pl);
            send_byte(tv[i].hdr);
            for (int k = 0; k < tv[i].nbytes; k++) send_byte(tv[i].data[8*k +: 8]);
            drain();
            chk("vec_err_pulses", 128'(err_seen - e0), 128'(tv[i].exp_err));
        end

        // Backpressure: packet held for 5 cycles.
        pkt_ready_i = 1'b0;
        push_exp(5'd3, 2'd2, 128'hCCBBAA);
        send_byte(8'h43);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        held = pkt_payload_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_valid", 128'(pkt_valid_o), 128'd1);
            chk("bp_byte_ready", 128'(byte_ready_o), 128'd0);
            chk("bp_payload_stable", pkt_payload_o, held);
        end
        @(posedge clk_i);
        #1;
        pkt_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("bp_after_valid", 128'(pkt_valid_o), 128'd0);
        chk("bp_after_ready", 128'(byte_ready_o), 128'd1);
        drain();

        // Filler and gaps.
        push_exp(5'd2, 2'd1, 128'h9911);
        send_byte(8'h00);
        send_byte(8'h22);
        send_byte(8'h11);
        idle(3);
        chk("gap_no_valid", 128'(pkt_valid_o), 128'd0);
        send_byte(8'h99);
        drain();

        // Oversize drop followed by a good packet.
        e0 = err_seen;
`ifdef TRDB_PACKET_READER_CNT_EN
        pc0 = pkt_count_o;
        dc0 = drop_count_o;
`endif
        push_exp(5'd1, 2'd0, 128'h5A);
        send_byte(8'h14);
        for (int k = 0; k < 20; k++) send_byte(8'(k + 8'hE0));
        send_byte(8'h01);
        send_byte(8'h5A);
        drain();
        chk("oversize_err_cycles", 128'(err_seen - e0), 128'd1);
`ifdef TRDB_PACKET_READER_CNT_EN
        chk("oversize_drop_cnt", 128'(drop_count_o - dc0), 128'd1);
        chk("oversize_pkt_cnt", 128'(pkt_count_o - pc0), 128'd1);
`endif

        // Reset in the middle of a payload.
        send_byte(8'h04);
        send_byte(8'h10);
        send_byte(8'h20);
        reset_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_i       = 8'h33;
        @(negedge clk_i);
        chk("rst_mid_ready", 128'(byte_ready_o), 128'd0);
        @(posedge clk_i);
        #1;
        reset_i      = 1'b0;
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_len", 128'(pkt_len_o), 128'd0);
        chk("rst_mid_valid", 128'(pkt_valid_o), 128'd0);
        @(posedge clk_i);
        #1;
        push_exp(5'd1, 2'd0, 128'h77);
        send_byte(8'h01);
        send_byte(8'h77);
        drain();

        // Maximum length, back-to-back: latency from header cycle to valid.
        push_exp(5'd16, 2'd0, 128'h0F0E0D0C0B0A09080706050403020100);
        rise_cyc = -1;
        c0 = cyc;
        send_byte(8'h10);
        for (int k = 0; k < 16; k++) send_byte(8'(k));
        drain();
        chk("max_latency", 128'(rise_cyc - c0), 128'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
